// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and byte/word helper functions for the
// iterative encryption core.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        NOKEY,
        KEYEXP,
        IDLE,
        ROUND
    } fsm_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Forward S-box, element 0 is the leftmost byte of the literal.
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic int unsigned nr_of(input int unsigned nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES cipher round; MixColumns is bypassed on the final round.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         final_i,
    output logic [127:0] state_o
);

    state_t sb_s;
    state_t sr_s;
    state_t mc_s;

    function automatic word_t mix_col(input word_t col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        sb_s    = '0;
        sr_s    = '0;
        mc_s    = '0;
        state_o = '0;
        for (int unsigned n = 0; n < 16; n++) begin
            sb_s[127 - 8*n -: 8] = sbox(state_i[127 - 8*n -: 8]);
        end
        // Byte 4c+r is row r of column c; row r rotates left by r columns.
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr_s[127 - 8*(4*c + r) -: 8] = sb_s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            mc_s[127 - 32*c -: 32] = mix_col(sr_s[127 - 32*c -: 32]);
        end
        state_o = (final_i ? sr_s : mc_s) ^ rkey_i;
    end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryptor: one key-schedule word or one cipher
// round per clock, with valid/ready handshakes on key, input and output.
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [32*NK-1:0]  key,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data
);

    localparam int unsigned NR     = nr_of(NK);
    localparam int unsigned NW     = 4 * (NR + 1);
    localparam logic [5:0]  LAST_W = 6'(NW - 1);
    localparam logic [5:0]  NK_W   = 6'(NK);
    localparam logic [2:0]  NK_M1  = 3'(NK - 1);
    localparam logic [3:0]  NR_L   = 4'(NR);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_enc_iter: NK must be 4, 6 or 8");
    end

    fsm_e       state_q, state_d;
    word_t      w_q [NW];
    logic [5:0] i_q, i_d;
    logic [2:0] mod_q, mod_d;
    logic [7:0] rcon_q, rcon_d;
    logic [3:0] rnd_q, rnd_d;
    state_t     st_q, st_d;
    state_t     out_q, out_d;
    logic       oval_q, oval_d;

    logic       key_acc;
    logic       blk_acc;
    logic       w_we;
    word_t      w_new;
    word_t      temp;
    state_t     rk;
    state_t     rnd_out;
    logic [5:0] rk_base;

    // rnd_q rests at 0 outside ROUND so the same mux yields rk[0] on accept.
    assign rk_base = {rnd_q, 2'b00};
    assign rk      = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};

    aes_round u_round (
        .state_i (st_q),
        .rkey_i  (rk),
        .final_i (rnd_q == NR_L),
        .state_o (rnd_out)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        mod_d     = mod_q;
        rcon_d    = rcon_q;
        rnd_d     = rnd_q;
        st_d      = st_q;
        out_d     = out_q;
        oval_d    = oval_q;
        w_we      = 1'b0;
        w_new     = '0;
        temp      = '0;
        key_ready = (state_q == NOKEY) || (state_q == IDLE);
        in_ready  = (state_q == IDLE) && !oval_q && !key_valid;
        key_acc   = key_valid && key_ready;
        blk_acc   = in_valid && in_ready;

        if (oval_q && out_ready) begin
            oval_d = 1'b0;
        end

        case (state_q)
            NOKEY, IDLE: begin
                if (key_acc) begin
                    i_d     = NK_W;
                    mod_d   = '0;
                    rcon_d  = RCON_INIT;
                    state_d = KEYEXP;
                end else if (blk_acc) begin
                    st_d    = in_data ^ rk;
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            KEYEXP: begin
                temp = w_q[i_q - 6'd1];
                if (mod_q == '0) begin
                    temp   = sub_word(rot_word(temp)) ^ {rcon_q, 24'h000000};
                    rcon_d = xtime(rcon_q);
                end else if (NK == 8 && mod_q == 3'd4) begin
                    temp = sub_word(temp);
                end
                w_new = w_q[i_q - NK_W] ^ temp;
                w_we  = 1'b1;
                i_d   = i_q + 6'd1;
                mod_d = (mod_q == NK_M1) ? '0 : mod_q + 3'd1;
                if (i_q == LAST_W) begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                st_d = rnd_out;
                if (rnd_q == NR_L) begin
                    out_d   = rnd_out;
                    oval_d  = 1'b1;
                    rnd_d   = '0;
                    state_d = IDLE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: state_d = NOKEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NOKEY;
            i_q     <= '0;
            mod_q   <= '0;
            rcon_q  <= RCON_INIT;
            rnd_q   <= '0;
            st_q    <= '0;
            out_q   <= '0;
            oval_q  <= 1'b0;
            for (int unsigned j = 0; j < NW; j++) begin
                w_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            mod_q   <= mod_d;
            rcon_q  <= rcon_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            out_q   <= out_d;
            oval_q  <= oval_d;
            if (key_acc) begin
                for (int unsigned j = 0; j < NK; j++) begin
                    w_q[j] <= key[32*(NK - j) - 1 -: 32];
                end
            end else if (w_we) begin
                w_q[i_q] <= w_new;
            end
        end
    end

    assign out_valid = oval_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: three instances (NK=4/6/8) checked against known
// vectors and a matrix-level AES model built from GF(2^8) arithmetic.
module tb_aes_enc_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        kv, kr, iv, ir, ov, ordy;
    logic [2:0][255:0] kb;
    logic [2:0][127:0] id, od;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_tab [256];

    aes_enc_iter #(.NK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[0]), .key_ready(kr[0]), .key(kb[0][127:0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]));
    aes_enc_iter #(.NK(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[1]), .key_ready(kr[1]), .key(kb[1][191:0]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]));
    aes_enc_iter #(.NK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[2]), .key_ready(kr[2]), .key(kb[2]),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]));

    typedef struct {
        int           d;
        logic [255:0] k;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vec [4];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    // Key in the low 32*nk bits; state held as s[row][col].
    function automatic logic [127:0] ref_enc(input logic [255:0] k, input int nk, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   coef [4];
        logic [31:0]  tmp;
        logic [7:0]   rc = 8'h01;
        logic [127:0] res = '0;
        int nr = nk + 6;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int j = 0; j < nk; j++) w[j] = k[32*(nk - 1 - j) +: 32];
        for (int j = nk; j < 4*(nr + 1); j++) begin
            tmp = w[j - 1];
            if (j % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && j % nk == 4) begin
                tmp = subw(tmp);
            end
            w[j] = w[j - nk] ^ tmp;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb_tab[s[r][(c + r) % 4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rd == nr) begin
                        s[r][c] = t[r][c];
                    end else begin
                        s[r][c] = '0;
                        for (int q = 0; q < 4; q++) s[r][c] ^= gmul(coef[(q - r + 4) % 4], t[q][c]);
                    end
                    s[r][c] ^= w[4*rd + c][31 - 8*r -: 8];
                end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127 - 8*(4*c + r) -: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input int d, input logic [255:0] k);
        int n = 0;
        int nk = 4 + 2*d;
        kb[d] = k;
        kv[d] = 1'b1;
        while (!kr[d] && n < 200) begin tick(); n++; end
        tick();
        kv[d] = 1'b0;
        kb[d] = {rand128(), rand128()};
        n = 0;
        while (!kr[d] && n < 200) begin tick(); n++; end
        chk($sformatf("keyexp_len_nk%0d", nk), 128'(n), 128'(3*nk + 28));
    endtask

    task automatic send_block(input int d, input logic [127:0] pt, output logic [127:0] ct, output int lat);
        int n = 0;
        iv[d] = 1'b1;
        id[d] = pt;
        while (!ir[d] && n < 200) begin tick(); n++; end
        if (n >= 200) chk("in_accept_timeout", 128'(n), 128'(0));
        tick();
        iv[d] = 1'b0;
        id[d] = rand128();
        lat = 0;
        while (!ov[d] && lat < 100) begin tick(); lat++; end
        ct = od[d];
    endtask

    task automatic drain(input int d);
        ordy[d] = 1'b1;
        tick();
        ordy[d] = 1'b0;
        chk("ov_clear", 128'(ov[d]), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [127:0] ct, pt, held;
        logic [255:0] k;
        logic [7:0]   inv;
        int lat, n, bad, acc, got, cyc, last, gap_bad;
        logic fin, fout;
        logic [127:0] expq [$];

        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
            end
            sb_tab[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        vec[0] = '{0, 256'h000102030405060708090a0b0c0d0e0f,
                   128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vec[1] = '{1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                   128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        vec[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};
        vec[3] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};

        kv = '0; iv = '0; ordy = '0; kb = '0; id = '0;
        repeat (2) tick();
        for (int d = 0; d < 3; d++) begin
            chk("rst_key_ready", 128'(kr[d]), 128'(1));
            chk("rst_in_ready", 128'(ir[d]), 128'(0));
            chk("rst_out_valid", 128'(ov[d]), 128'(0));
            chk("rst_out_data", od[d], 128'(0));
        end
        rst_n = 1'b1;

        iv[0] = 1'b1;
        id[0] = rand128();
        bad = 0;
        repeat (5) begin tick(); if (ir[0] || ov[0]) bad++; end
        iv[0] = 1'b0;
        chk("nokey_no_accept", 128'(bad), 128'(0));

        // In-valid held through key expansion must not be accepted early.
        kb[0] = vec[0].k; kv[0] = 1'b1; iv[0] = 1'b1; id[0] = vec[0].pt;
        tick();
        kv[0] = 1'b0;
        bad = 0; n = 0;
        while (!kr[0] && n < 200) begin if (ir[0] || ov[0]) bad++; tick(); n++; end
        iv[0] = 1'b0;
        chk("keyexp_no_accept", 128'(bad), 128'(0));
        chk("keyexp_len_first", 128'(n), 128'(40));

        for (int v = 0; v < 4; v++) begin
            load_key(vec[v].d, vec[v].k);
            send_block(vec[v].d, vec[v].pt, ct, lat);
            chk($sformatf("vec%0d_ct", v), ct, vec[v].ct);
            chk($sformatf("vec%0d_lat", v), 128'(lat), 128'(10 + 2*vec[v].d));
            if (v == 3) begin
                bad = 0;
                iv[0] = 1'b1;
                id[0] = rand128();
                repeat (20) begin
                    tick();
                    if (od[0] !== vec[3].ct || !ov[0] || ir[0]) bad++;
                end
                iv[0] = 1'b0;
                chk("hold_stable", 128'(bad), 128'(0));
                load_key(0, vec[0].k);
                chk("reload_keeps_ov", 128'(ov[0]), 128'(1));
                chk("reload_keeps_data", od[0], vec[3].ct);
            end
            drain(vec[v].d);
        end

        // Key and block offered together: key wins, block waits for the new schedule.
        k = {rand128(), rand128()};
        pt = rand128();
        kb[0] = k; kv[0] = 1'b1; iv[0] = 1'b1; id[0] = pt;
        tick();
        kv[0] = 1'b0;
        n = 0;
        while (!ir[0] && n < 200) begin tick(); n++; end
        chk("simul_wait", 128'(n), 128'(40));
        tick();
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 100) begin tick(); lat++; end
        chk("simul_ct", od[0], ref_enc(k, 4, pt));
        drain(0);

        for (int d = 0; d < 3; d++) begin
            k = {rand128(), rand128()};
            load_key(d, k);
            repeat (3) begin
                pt = rand128();
                send_block(d, pt, ct, lat);
                chk($sformatf("rand_ct_nk%0d", 4 + 2*d), ct, ref_enc(k, 4 + 2*d, pt));
                chk($sformatf("rand_lat_nk%0d", 4 + 2*d), 128'(lat), 128'(10 + 2*d));
                repeat ($urandom_range(0, 3)) tick();
                drain(d);
            end
        end

        // Streaming: accept -> NR rounds -> one cycle with out_valid -> accept again.
        k = {rand128(), rand128()};
        load_key(1, k);
        ordy[1] = 1'b1; iv[1] = 1'b1; id[1] = rand128();
        acc = 0; got = 0; cyc = 0; last = -1; gap_bad = 0;
        while (got < 5 && cyc < 1000) begin
            fin  = iv[1] && ir[1];
            fout = ov[1] && ordy[1];
            if (fout) begin
                if (expq.size() == 0) chk("b2b_spurious", 128'(1), 128'(0));
                else chk("b2b_ct", od[1], expq.pop_front());
                got++;
            end
            if (fin) begin
                expq.push_back(ref_enc(k, 6, id[1]));
                if (last >= 0 && cyc - last != 14) gap_bad++;
                last = cyc;
            end
            tick();
            cyc++;
            if (fin) begin
                acc++;
                if (acc < 5) id[1] = rand128();
                else iv[1] = 1'b0;
            end
        end
        ordy[1] = 1'b0;
        chk("b2b_count", 128'(got), 128'(5));
        chk("b2b_gap", 128'(gap_bad), 128'(0));

        kb[0] = {rand128(), rand128()}; kv[0] = 1'b1;
        tick();
        kv[0] = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("rstkx_key_ready", 128'(kr[0]), 128'(1));
        chk("rstkx_in_ready", 128'(ir[0]), 128'(0));
        tick();
        rst_n = 1'b1;

        k = {rand128(), rand128()};
        load_key(2, k);
        send_block(2, rand128(), ct, lat);
        load_key(0, vec[3].k);
        iv[0] = 1'b1; id[0] = vec[3].pt;
        tick();
        iv[0] = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("rstrd_ov0", 128'(ov[0]), 128'(0));
        chk("rstrd_ov2", 128'(ov[2]), 128'(0));
        chk("rstrd_od2", od[2], 128'(0));
        chk("rstrd_key_ready", 128'(kr[0]), 128'(1));
        tick();
        rst_n = 1'b1;
        iv = 3'b111;
        bad = 0;
        repeat (30) begin tick(); if (ov != 3'b000 || ir != 3'b000) bad++; end
        iv = '0;
        chk("post_reset_quiet", 128'(bad), 128'(0));

        load_key(0, vec[3].k);
        send_block(0, vec[3].pt, ct, lat);
        chk("post_reset_ct", ct, vec[3].ct);
        drain(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
